module_instruction_fetch: RTL and testbench
===========================================

Name: module_instruction_fetch

Overview:
Fetch stage sitting directly upstream of the instruction memory. It owns the program counter and drives the instruction memory byte address. It captures the returned word into an IF/ID output register and hands it to decode over a valid/ready handshake. It supports branch/jump redirect with flush, back-pressure stall, a run gate so that fetch does not start until the iRAM is programmed, and a halt opcode.

Parameters:
ADDRESS_BITS, 32, width of PC and instruction memory address
WORD_SIZE, 32, instruction width
RESET_PC, 0, PC value after reset and on every IDLE->FETCH entry
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = fetch permitted, 0 = return to IDLE
imem_addr  output  ADDRESS_BITS  byte address to instruction memory (equals PC register)
imem_instruction  input  WORD_SIZE  word returned by instruction memory for imem_addr, valid in the same cycle
branch_valid  input  1  one-cycle redirect request from execute
branch_target  input  ADDRESS_BITS  redirect byte address
out_valid  output  1  out_* holds a valid fetched instruction
out_ready  input  1  decode accepts out_* this cycle
out_instruction  output  WORD_SIZE  fetched instruction
out_pc  output  ADDRESS_BITS  address of out_instruction
out_pc_plus4  output  ADDRESS_BITS  out_pc + 4, modulo 2^ADDRESS_BITS
halted  output  1  high while in HALT state

Behaviour:
- Reset (reset=1 at an edge): state=IDLE, pc=RESET_PC, out_valid=0, out_instruction=0, out_pc=0, out_pc_plus4=0, halted=0. Reset has priority over every other input.
- imem_addr = pc at all times (combinational from register). There is no reset-dependent gating.
- States:
  - IDLE: no capture. pc is held at RESET_PC. On run=1, move to FETCH next edge. No instruction is captured on that edge.
  - FETCH: described below.
  - HALT: halted=1. pc is frozen. out_valid is held until it is accepted, then falls to 0. run=0 moves to IDLE and clears halted. branch_valid is ignored.
- run=0 in FETCH or HALT: next state=IDLE, pc<=RESET_PC, out_valid<=0. This has priority over branch, stall and capture.
- Advance condition: adv = !out_valid || out_ready.
- FETCH priority, highest first:
  1. Branch: if branch_valid=1, then pc <= {branch_target[ADDRESS_BITS-1:2],2'b00} and out_valid <= 0 (flush, even if stalled). No capture occurs that cycle. The redirect penalty is one bubble.
  2. Capture: else if adv=1, then out_instruction <= imem_instruction, out_pc <= pc, out_pc_plus4 <= pc+4, and out_valid <= 1.
     - If imem_instruction == HALT_WORD: pc is held and the next state is HALT. The halt word is delivered to decode.
     - Else pc <= pc+4.
  3. Stall: else (out_valid=1, out_ready=0), all registers are held.
- Throughput: one instruction per cycle while out_ready=1. Latency is one cycle from PC to out_*.
- PC arithmetic wraps modulo 2^ADDRESS_BITS. The PC is always word aligned; bits [1:0] are always 0.
- out_* must not change while out_valid=1 and out_ready=0, except for a flush or for run=0.

Decomposition:
- Shared package holds:
  - state encoding constants FETCH_IDLE=2'd0, FETCH_RUN=2'd1, FETCH_HALT=2'd2;
  - PC_STEP=4;
  - the HALT_WORD default, so decode can match the same encoding.
- One natural sub-module, module_program_counter: pc register with load/increment/hold controls and alignment masking. The FSM and the IF/ID register stay in the top.

Test Plan:
- Reset then run=1, out_ready=1, imem returns mem[addr/4] from a model holding 0x2000_0001, 0x2020_0001, 0x0002_0800 -> out_pc 0, 4, 8 on consecutive cycles with matching instructions. out_valid is first high 2 cycles after run rises.
- Stall: out_ready=0 for 3 cycles after the second capture -> out_pc stays 4, imem_addr stays 8. On release, out_pc=8 on the next cycle with no skipped or duplicated word.
- Branch during stall: out_valid=1, out_ready=0, branch_valid=1 with target 0x43 -> next cycle out_valid=0 and imem_addr=0x40. The cycle after that, out_pc=0x40.
- Halt: word at 0xC is HALT_WORD -> it is delivered with out_pc=0xC and halted=1. imem_addr is frozen at 0xC. A branch_valid during HALT has no effect.
- Wrap: RESET_PC=32'hFFFF_FFFC -> first out_pc=0xFFFF_FFFC with out_pc_plus4=0, and the next out_pc=0.
- Mid-operation controls: reset or run=0 asserted during a stall -> out_valid=0 and pc=RESET_PC next cycle. After run returns to 1, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/module_instruction_fetch_pkg.sv
// rtl/module_instruction_fetch_pkg.sv - shared fetch-stage encodings and constants
package module_instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

  localparam int PC_STEP = 4;

  // Decode matches against the same encoding to recognise the stop instruction.
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/module_instruction_fetch_if.sv
// rtl/module_instruction_fetch_if.sv - imem, redirect and IF/ID handshake bundle
interface module_instruction_fetch_if #(
  parameter int ADDRESS_BITS = 32,
  parameter int WORD_SIZE    = 32
);
  logic [ADDRESS_BITS-1:0] imem_addr;
  logic [WORD_SIZE-1:0]    imem_instruction;
  logic                    branch_valid;
  logic [ADDRESS_BITS-1:0] branch_target;
  logic                    out_valid;
  logic                    out_ready;
  logic [WORD_SIZE-1:0]    out_instruction;
  logic [ADDRESS_BITS-1:0] out_pc;
  logic [ADDRESS_BITS-1:0] out_pc_plus4;
  logic                    halted;

  modport master (
    output imem_addr,
    input  imem_instruction,
    input  branch_valid,
    input  branch_target,
    output out_valid,
    input  out_ready,
    output out_instruction,
    output out_pc,
    output out_pc_plus4,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_instruction,
    output branch_valid,
    output branch_target,
    input  out_valid,
    output out_ready,
    input  out_instruction,
    input  out_pc,
    input  out_pc_plus4,
    input  halted
  );
endinterface

// File: rtl/module_instruction_fetch_program_counter.sv
// rtl/module_instruction_fetch_program_counter.sv - word-aligned PC with restart/load/increment
module module_program_counter
  import module_instruction_fetch_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_restart,
  input  logic                    i_load,
  input  logic [ADDRESS_BITS-1:0] i_load_addr,
  input  logic                    i_inc,
  output logic [ADDRESS_BITS-1:0] o_pc
);

  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

  logic [ADDRESS_BITS-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset || i_restart) begin
      r_pc <= RESET_PC & ALIGN_MASK;
    end else if (i_load) begin
      r_pc <= i_load_addr & ALIGN_MASK;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDRESS_BITS'(PC_STEP);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/module_instruction_fetch.sv
// rtl/module_instruction_fetch.sv - fetch stage: run/halt FSM, PC control, IF/ID register
module module_instruction_fetch
  import module_instruction_fetch_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 32,
  parameter int                      WORD_SIZE    = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
  parameter logic [WORD_SIZE-1:0]    HALT_WORD    = WORD_SIZE'(HALT_WORD_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  module_instruction_fetch_if.master  bus
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [ADDRESS_BITS-1:0] w_pc;
  logic                    w_pc_restart;
  logic                    w_pc_load;
  logic                    w_pc_inc;
  logic                    w_capture;
  logic                    w_clear_valid;
  logic                    w_adv;

  logic                    r_out_valid;
  logic [WORD_SIZE-1:0]    r_out_instruction;
  logic [ADDRESS_BITS-1:0] r_out_pc;
  logic [ADDRESS_BITS-1:0] r_out_pc_plus4;

  assign w_adv = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Priority in FETCH: run drop, then redirect, then capture, else stall.
  always_comb begin
    w_next_state  = r_state;
    w_pc_restart  = 1'b0;
    w_pc_load     = 1'b0;
    w_pc_inc      = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        w_pc_restart = 1'b1;
        if (run) begin
          w_next_state = FETCH_RUN;
        end
      end
      FETCH_RUN: begin
        if (!run) begin
          w_next_state  = FETCH_IDLE;
          w_pc_restart  = 1'b1;
          w_clear_valid = 1'b1;
        end else if (bus.branch_valid) begin
          w_pc_load     = 1'b1;
          w_clear_valid = 1'b1;
        end else if (w_adv) begin
          w_capture = 1'b1;
          if (bus.imem_instruction == HALT_WORD) begin
            w_next_state = FETCH_HALT;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      FETCH_HALT: begin
        if (!run) begin
          w_next_state  = FETCH_IDLE;
          w_pc_restart  = 1'b1;
          w_clear_valid = 1'b1;
        end else if (r_out_valid && bus.out_ready) begin
          w_clear_valid = 1'b1;
        end
      end
      default: begin
        w_next_state  = FETCH_IDLE;
        w_pc_restart  = 1'b1;
        w_clear_valid = 1'b1;
      end
    endcase
  end

  module_program_counter #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .RESET_PC     (RESET_PC)
  ) u_program_counter (
    .clk         (clk),
    .reset       (reset),
    .i_restart   (w_pc_restart),
    .i_load      (w_pc_load),
    .i_load_addr (bus.branch_target),
    .i_inc       (w_pc_inc),
    .o_pc        (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid       <= 1'b0;
      r_out_instruction <= '0;
      r_out_pc          <= '0;
      r_out_pc_plus4    <= '0;
    end else if (w_clear_valid) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid       <= 1'b1;
      r_out_instruction <= bus.imem_instruction;
      r_out_pc          <= w_pc;
      r_out_pc_plus4    <= w_pc + ADDRESS_BITS'(PC_STEP);
    end
  end

  assign bus.imem_addr       = w_pc;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_instruction = r_out_instruction;
  assign bus.out_pc          = r_out_pc;
  assign bus.out_pc_plus4    = r_out_pc_plus4;
  assign bus.halted          = (r_state == FETCH_HALT);

endmodule

// File: tb/tb_module_instruction_fetch.sv
// tb/tb_module_instruction_fetch.sv - directed and randomized checks against a behavioural fetch model
module tb_module_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        ready = 1'b1;
  logic        bv = 1'b0;
  logic [31:0] bt = '0;
  logic [31:0] mem [64];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  module_instruction_fetch_if #(.ADDRESS_BITS(32), .WORD_SIZE(32)) bus0 ();
  module_instruction_fetch_if #(.ADDRESS_BITS(32), .WORD_SIZE(32)) bus1 ();

  module_instruction_fetch #(
    .ADDRESS_BITS(32), .WORD_SIZE(32), .RESET_PC(32'h0), .HALT_WORD(HALT)
  ) dut0 (.clk(clk), .reset(reset), .run(run), .bus(bus0));

  module_instruction_fetch #(
    .ADDRESS_BITS(32), .WORD_SIZE(32), .RESET_PC(32'hFFFF_FFFC), .HALT_WORD(HALT)
  ) dut1 (.clk(clk), .reset(reset), .run(run), .bus(bus1));

  assign bus0.branch_valid  = bv;
  assign bus0.branch_target = bt;
  assign bus0.out_ready     = ready;
  assign bus1.branch_valid  = bv;
  assign bus1.branch_target = bt;
  assign bus1.out_ready     = ready;

  // Low 256 bytes come from mem; everything above is a fixed pattern that is never HALT.
  assign bus0.imem_instruction = (bus0.imem_addr < 32'd256) ? mem[bus0.imem_addr[7:2]]
                                 : ({1'b0, bus0.imem_addr[30:0]} ^ 32'h1234_5670);
  assign bus1.imem_instruction = (bus1.imem_addr < 32'd256) ? mem[bus1.imem_addr[7:2]]
                                 : ({1'b0, bus1.imem_addr[30:0]} ^ 32'h1234_5670);

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return {1'b0, a[30:0]} ^ 32'h1234_5670;
  endfunction

  // Behavioural model: mode 0 = idle, 1 = fetching, 2 = halted.
  int          m_mode [2];
  logic [31:0] m_pc   [2];
  logic        m_ov   [2];
  logic [31:0] m_oi   [2];
  logic [31:0] m_opc  [2];
  logic [31:0] m_op4  [2];
  bit          model_ok = 0;

  function automatic logic [31:0] start_pc(input int i);
    return (i == 1) ? 32'hFFFF_FFFC : 32'h0;
  endfunction

  task automatic model_step(input int i);
    logic [31:0] w;
    if (reset) begin
      m_mode[i] = 0; m_pc[i] = start_pc(i); m_ov[i] = 0;
      m_oi[i] = 0; m_opc[i] = 0; m_op4[i] = 0;
    end else if (m_mode[i] != 0 && !run) begin
      m_mode[i] = 0; m_pc[i] = start_pc(i); m_ov[i] = 0;
    end else if (m_mode[i] == 0) begin
      m_pc[i] = start_pc(i);
      if (run) m_mode[i] = 1;
    end else if (m_mode[i] == 2) begin
      if (m_ov[i] && ready) m_ov[i] = 0;
    end else if (bv) begin
      m_pc[i] = {bt[31:2], 2'b00};
      m_ov[i] = 0;
    end else if (!m_ov[i] || ready) begin
      w = imem_word(m_pc[i]);
      m_oi[i] = w; m_opc[i] = m_pc[i]; m_op4[i] = m_pc[i] + 32'd4; m_ov[i] = 1;
      if (w == HALT) m_mode[i] = 2;
      else m_pc[i] = m_pc[i] + 32'd4;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset || model_ok) model_step(i);
    end
    if (reset) model_ok = 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("dut0 imem_addr", bus0.imem_addr, m_pc[0]);
      chk("dut0 out_valid", 32'(bus0.out_valid), 32'(m_ov[0]));
      chk("dut0 out_instruction", bus0.out_instruction, m_oi[0]);
      chk("dut0 out_pc", bus0.out_pc, m_opc[0]);
      chk("dut0 out_pc_plus4", bus0.out_pc_plus4, m_op4[0]);
      chk("dut0 halted", 32'(bus0.halted), 32'(m_mode[0] == 2));
      chk("dut1 imem_addr", bus1.imem_addr, m_pc[1]);
      chk("dut1 out_valid", 32'(bus1.out_valid), 32'(m_ov[1]));
      chk("dut1 out_instruction", bus1.out_instruction, m_oi[1]);
      chk("dut1 out_pc", bus1.out_pc, m_opc[1]);
      chk("dut1 out_pc_plus4", bus1.out_pc_plus4, m_op4[1]);
      chk("dut1 halted", 32'(bus1.halted), 32'(m_mode[1] == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    mem[0] = 32'h2000_0001;
    mem[1] = 32'h2020_0001;
    mem[2] = 32'h0002_0800;
    mem[3] = HALT;

    tick(); tick();
    reset = 0;
    tick();
    chk("reset out_valid", 32'(bus0.out_valid), 32'd0);
    chk("reset imem_addr", bus0.imem_addr, 32'h0);
    chk("reset out_pc", bus0.out_pc, 32'h0);
    chk("reset halted", 32'(bus0.halted), 32'd0);

    run = 1;
    tick();
    chk("first cycle no capture", 32'(bus0.out_valid), 32'd0);
    tick();
    chk("cap0 valid", 32'(bus0.out_valid), 32'd1);
    chk("cap0 pc", bus0.out_pc, 32'h0);
    chk("cap0 instr", bus0.out_instruction, 32'h2000_0001);
    chk("wrap first pc", bus1.out_pc, 32'hFFFF_FFFC);
    chk("wrap first pc_plus4", bus1.out_pc_plus4, 32'h0);
    tick();
    chk("cap1 pc", bus0.out_pc, 32'h4);
    chk("cap1 instr", bus0.out_instruction, 32'h2020_0001);
    chk("wrap second pc", bus1.out_pc, 32'h0);

    ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall out_pc", bus0.out_pc, 32'h4);
      chk("stall imem_addr", bus0.imem_addr, 32'h8);
    end
    ready = 1;
    tick();
    chk("release pc", bus0.out_pc, 32'h8);
    chk("release instr", bus0.out_instruction, 32'h0002_0800);

    ready = 0; bv = 1; bt = 32'h43;
    tick();
    chk("flush valid", 32'(bus0.out_valid), 32'd0);
    chk("branch imem_addr", bus0.imem_addr, 32'h40);
    bv = 0; ready = 1;
    tick();
    chk("branch out_pc", bus0.out_pc, 32'h40);

    run = 0;
    tick();
    chk("run0 valid", 32'(bus0.out_valid), 32'd0);
    chk("run0 imem_addr", bus0.imem_addr, 32'h0);
    run = 1;
    tick(); tick(); tick(); tick(); tick();
    chk("halt out_pc", bus0.out_pc, 32'hC);
    chk("halt instr", bus0.out_instruction, HALT);
    chk("halt halted", 32'(bus0.halted), 32'd1);
    ready = 0; bv = 1; bt = 32'h80;
    tick();
    chk("halt ignores branch", bus0.imem_addr, 32'hC);
    chk("halt holds valid", 32'(bus0.out_valid), 32'd1);
    bv = 0; ready = 1;
    tick();
    chk("halt accepted", 32'(bus0.out_valid), 32'd0);
    chk("halt frozen", bus0.imem_addr, 32'hC);

    run = 0; tick();
    run = 1; tick(); tick();
    ready = 0; tick();
    chk("stall before run0", bus0.out_pc, 32'h0);
    run = 0; tick();
    chk("run0 in stall valid", 32'(bus0.out_valid), 32'd0);
    chk("run0 in stall pc", bus0.imem_addr, 32'h0);
    run = 1; ready = 1; tick(); tick();
    chk("restart pc", bus0.out_pc, 32'h0);
    ready = 0; tick();
    reset = 1; tick();
    chk("reset in stall valid", 32'(bus0.out_valid), 32'd0);
    chk("reset in stall pc", bus0.imem_addr, 32'h0);

    for (int k = 0; k < 64; k++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      if ($urandom_range(0, 31) == 0) w = HALT;
      mem[k] = w;
    end
    tick();
    reset = 0;
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      run   = ($urandom_range(0, 19) != 0);
      ready = ($urandom_range(0, 9) < 7);
      bv    = ($urandom_range(0, 9) == 0);
      bt    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      tick();
    end
    reset = 0; run = 0; bv = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
